// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
// Provides datapath widths, the PC increment, the default reset vector,
// the canonical NOP encoding, the fetch-queue entry layout and a PC
// alignment helper used by the fetch stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] PC_INC           = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

  // One fetch-queue entry: the PC is kept next to its instruction so decode
  // never has to reconstruct it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO used as the fetch queue.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   flush      : discard all entries (pointers and count cleared)
//   push/wdata : write wdata at the tail
//   pop        : consume the head
//   count      : current occupancy (0..DEPTH)
//   rdata      : head entry, driven to zero while empty
// A push and pop in the same cycle is accepted even when full.
module fetch_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [PTR_W:0]   count,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE        = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Guard against underflow/overflow locally so the FIFO stays safe on its own.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count < FULL_COUNT) | do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Owns the program counter, drives it to instruction memory, captures each
// {pc, instruction} pair into the fetch queue and hands them to decode with
// a valid/ready handshake. Redirects flush the queue and reload the PC.
// Ports:
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   imem_addr / imem_data   : word address out, instruction back same cycle
//   redirect_valid/_pc      : taken branch/jump target (low bits ignored)
//   if_valid/if_instr/if_pc : queue head presented to decode
//   id_ready                : decode accepts the head this cycle
//   fetch_count             : queue occupancy
module fetch_unit
  import riscv_pkg::*;
#(
  parameter  logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter  int unsigned DEPTH    = 2,
  localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [ILEN-1:0]  imem_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             if_valid,
  output logic [ILEN-1:0]  if_instr,
  output logic [XLEN-1:0]  if_pc,
  input  logic             id_ready,
  output logic [PTR_W:0]   fetch_count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic            pop;
  logic            push;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;
  logic [ENTRY_W-1:0] head_bits;

  assign pop  = if_valid & id_ready;
  // A redirect never pushes: the instruction on imem_data belongs to the
  // wrong path.
  assign push = !redirect_valid & ((fetch_count < FULL_COUNT) | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_INC;
    end
  end

  assign imem_addr = fetch_pc;

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = fetch_pc;
    wr_entry.instr = imem_data;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .count (fetch_count),
    .rdata (head_bits)
  );

  assign head     = fetch_entry_t'(head_bits);
  assign if_valid = (fetch_count != '0);
  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model tracks
// the instruction stream decode should see; a monitor compares every cycle.
module tb_fetch_unit;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic             clk;
  logic             reset;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic             id_ready;
  logic [PTR_W:0]   fetch_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents.
  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h0020_81B3;
      default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  assign imem_data = memf(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {pc, instr} awaiting decode plus the
  // next PC to fetch. Decode consumes from the front; fetch appends while
  // there is room (room freed by a consume in the same cycle counts).
  logic [63:0] exp_q[$];
  logic [31:0] mpc;
  bit          model_live = 0;

  always @(posedge clk) begin
    bit consumed;
    if (reset) begin
      exp_q.delete();
      mpc = RST_PC;
      model_live = 1;
    end else if (model_live) begin
      consumed = (exp_q.size() != 0) && id_ready;
      if (redirect_valid) begin
        exp_q.delete();
        mpc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (consumed) void'(exp_q.pop_front());
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back({mpc, memf(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  // Monitor: compare DUT against model front on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("if_valid", {31'd0, if_valid}, {31'd0, exp_q.size() != 0});
      chk("fetch_count", 32'(fetch_count), 32'(exp_q.size()));
      chk("imem_addr", imem_addr, mpc);
      if (exp_q.size() != 0) begin
        chk("if_pc", if_pc, exp_q[0][63:32]);
        chk("if_instr", if_instr, exp_q[0][31:0]);
      end else begin
        chk("if_pc_empty", if_pc, 32'd0);
        chk("if_instr_empty", if_instr, 32'd0);
      end
    end
  end

  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    repeat (3) step(1, 0, 0, 1);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);

    // Start-up and steady stream.
    step(0, 0, 0, 1);
    chk("first_pc", if_pc, 32'h0);
    chk("first_instr", if_instr, 32'h0050_0093);
    step(0, 0, 0, 1);
    chk("pc4", if_pc, 32'h4);
    chk("instr4", if_instr, 32'h00A0_0113);
    step(0, 0, 0, 1);
    chk("pc8", if_pc, 32'h8);
    chk("instr8", if_instr, 32'h0020_81B3);

    // Stall.
    repeat (5) step(0, 0, 0, 0);
    chk("stall_count", 32'(fetch_count), 32'd2);
    chk("stall_addr", imem_addr, 32'h10);
    chk("stall_pc", if_pc, 32'h8);
    step(0, 0, 0, 1);
    chk("release_pc_c", if_pc, 32'hC);
    step(0, 0, 0, 1);
    chk("release_pc_10", if_pc, 32'h10);

    // Redirect while full.
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 32'h100, 0);
    chk("redir_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_count", 32'(fetch_count), 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    step(0, 0, 0, 1);
    chk("redir_pc", if_pc, 32'h100);

    // Misaligned target.
    step(0, 1, 32'h0000_0206, 1);
    chk("mis_addr", imem_addr, 32'h204);
    step(0, 0, 0, 1);
    chk("mis_pc", if_pc, 32'h204);

    // PC wrap.
    step(0, 1, 32'hFFFF_FFF8, 1);
    step(0, 0, 0, 1);
    chk("wrap_pc0", if_pc, 32'hFFFF_FFF8);
    step(0, 0, 0, 1);
    chk("wrap_pc1", if_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap_pc2", if_pc, 32'h0);

    // Reset mid-stream with a full queue; reset also beats a redirect.
    repeat (2) step(0, 0, 0, 0);
    chk("pre_rst_count", 32'(fetch_count), 32'd2);
    step(1, 1, 32'h300, 0);
    chk("midrst_valid", {31'd0, if_valid}, 32'd0);
    chk("midrst_count", 32'(fetch_count), 32'd0);
    chk("midrst_addr", imem_addr, RST_PC);
    step(0, 0, 0, 1);
    chk("restart_pc", if_pc, RST_PC);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 19) == 0),
           tgt,
           ($urandom_range(0, 3) != 0));
    end
    step(0, 0, 0, 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
